// File: rtl/frame_run_controller.sv
// Run sequencer for one frame-generator test: latches the port config, starts the
// generator, counts completed frames, stops on target/timeout/abort and reports.
package frame_run_pkg;
    typedef struct packed {
        logic [31:0] dst_addr;
        logic [31:0] src_addr;
        logic [15:0] frame_size;
    } port_config_t;
endpackage

module frame_run_controller
    import frame_run_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_start,
    input  logic                   cmd_abort,
    input  port_config_t           cfg_port_config,
    input  logic [COUNT_WIDTH-1:0] cfg_frame_count,
    input  logic [COUNT_WIDTH-1:0] cfg_max_cycles,
    input  logic                   gen_ready,
    output logic                   gen_start,
    output logic                   gen_stop,
    output port_config_t           gen_port_config,
    input  logic                   mon_valid,
    input  logic                   mon_ready,
    input  logic                   mon_last,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] frames_sent,
    output logic [COUNT_WIDTH-1:0] cycles_elapsed,
    output logic [1:0]             stop_reason
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                 state_q, state_d;
    port_config_t           cfg_q;
    logic [COUNT_WIDTH-1:0] target_q, limit_q;
    logic [COUNT_WIDTH-1:0] frames_q, frames_d;
    logic [COUNT_WIDTH-1:0] cycles_q, cycles_d;
    logic [1:0]             reason_q, reason_d;

    logic                   frame_done;
    logic                   accept;
    logic                   counting;
    logic                   hit_count, hit_timeout;
    logic [COUNT_WIDTH:0]   frames_inc, cycles_inc, target_m1;

    assign frame_done = mon_valid & mon_ready & mon_last;
    assign accept     = (state_q == S_IDLE) & cmd_start & gen_ready & ~cmd_abort;
    assign counting   = (state_q == S_RUN) | (state_q == S_DRAIN);

    // One extra bit keeps the stop comparisons exact when the counters sit at all-ones.
    assign frames_inc  = {1'b0, frames_q} + {{COUNT_WIDTH{1'b0}}, frame_done};
    assign cycles_inc  = {1'b0, cycles_q} + {{COUNT_WIDTH{1'b0}}, 1'b1};
    assign target_m1   = {1'b0, target_q} - {{COUNT_WIDTH{1'b0}}, 1'b1};
    assign hit_count   = (target_q != '0) && (frames_inc >= target_m1);
    assign hit_timeout = (limit_q != '0) && (cycles_inc >= {1'b0, limit_q});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        reason_d = reason_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_LAUNCH;
                    reason_d = 2'd0;
                end
            end
            S_LAUNCH: state_d = S_RUN;
            S_RUN: begin
                if (hit_count) begin
                    state_d  = S_DRAIN;
                    reason_d = 2'd1;
                end else if (hit_timeout) begin
                    state_d  = S_DRAIN;
                    reason_d = 2'd2;
                end else if (cmd_abort) begin
                    state_d  = S_DRAIN;
                    reason_d = 2'd3;
                end
            end
            S_DRAIN: begin
                if (gen_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gen_start = (state_q == S_LAUNCH);
        gen_stop  = (state_q == S_DRAIN);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
    end

    always_comb begin
        frames_d = frames_q;
        cycles_d = cycles_q;
        if (accept) begin
            frames_d = '0;
            cycles_d = '0;
        end else if (counting) begin
            frames_d = frames_inc[COUNT_WIDTH] ? CNT_MAX : frames_inc[COUNT_WIDTH-1:0];
            cycles_d = cycles_inc[COUNT_WIDTH] ? CNT_MAX : cycles_inc[COUNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_q    <= '0;
            target_q <= '0;
            limit_q  <= '0;
            frames_q <= '0;
            cycles_q <= '0;
            reason_q <= '0;
        end else begin
            frames_q <= frames_d;
            cycles_q <= cycles_d;
            reason_q <= reason_d;
            if (accept) begin
                cfg_q    <= cfg_port_config;
                target_q <= cfg_frame_count;
                limit_q  <= cfg_max_cycles;
            end
        end
    end

    assign gen_port_config = cfg_q;
    assign frames_sent     = frames_q;
    assign cycles_elapsed  = cycles_q;
    assign stop_reason     = reason_q;

endmodule

// File: tb/tb_frame_run_controller.sv
// Bench for frame_run_controller: a reactive generator model drives the taps and an
// array-based reference recomputes stop point, drain end and counters for each run.
module tb_frame_run_controller;
    import frame_run_pkg::*;

    localparam int unsigned CW   = 10;
    localparam int          MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n, cmd_start, cmd_abort, gen_ready;
    logic          gen_start, gen_stop, mon_valid, mon_ready, mon_last, busy, done;
    port_config_t  cfg_port_config, gen_port_config;
    logic [CW-1:0] cfg_frame_count, cfg_max_cycles, frames_sent, cycles_elapsed;
    logic [1:0]    stop_reason;

    frame_run_controller #(.COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .cfg_port_config(cfg_port_config), .cfg_frame_count(cfg_frame_count),
        .cfg_max_cycles(cfg_max_cycles), .gen_ready(gen_ready), .gen_start(gen_start),
        .gen_stop(gen_stop), .gen_port_config(gen_port_config), .mon_valid(mon_valid),
        .mon_ready(mon_ready), .mon_last(mon_last), .busy(busy), .done(done),
        .frames_sent(frames_sent), .cycles_elapsed(cycles_elapsed), .stop_reason(stop_reason)
    );

    always #5 clk = ~clk;

    typedef struct {
        int count; int maxc; int fsize; bit rnd_ready; int abort_frame; bit start_drain;
        int exp_reason; int exp_frames; int exp_cycles; int exp_stop_n; int exp_taps;
    } vec_t;

    int checks = 0;
    int passed = 0;
    int last_frames = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int sat(input int x);
        return (x > MAXV) ? MAXV : x;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_gen_start"}, gen_start, 0);
        check({tag, "_gen_stop"}, gen_stop, 0);
        check({tag, "_frames"}, frames_sent, 0);
        check({tag, "_cycles"}, cycles_elapsed, 0);
        check({tag, "_reason"}, stop_reason, 0);
        check({tag, "_cfg"}, gen_port_config, 0);
    endtask

    task automatic run_case(input vec_t v, input string tag);
        bit fd_q[$], rdy_q[$], ab_q[$], st_q[$], sp_q[$], dn_q[$], by_q[$];
        port_config_t cfg;
        int beats, beat, taps, hs_beats, post, k, j, sum, reason, idx, first_stop;
        int e_start, e_stop, e_done, e_busy;
        bit act, p_start, p_hs, p_last, p_stop, aborted, sent2, seen_done;
        bit x_stop, x_done, x_busy;
        beats = (v.fsize + 63) / 64;
        if (beats < 1) beats = 1;
        cfg.dst_addr   = $urandom;
        cfg.src_addr   = $urandom;
        cfg.frame_size = 16'(v.fsize);
        @(negedge clk);
        cfg_port_config = cfg;
        cfg_frame_count = CW'(v.count);
        cfg_max_cycles  = CW'(v.maxc);
        cmd_start = 1'b1; cmd_abort = 1'b0; gen_ready = 1'b1;
        mon_valid = 1'b0; mon_last = 1'b0; mon_ready = 1'b1;
        act = 0; beat = 0; p_start = 0; p_hs = 0; p_last = 0; p_stop = 0;
        taps = 0; hs_beats = 0; aborted = 0; sent2 = 0; seen_done = 0; post = 0;
        // Entry n of each array is the cycle n after the start request; n=0 must be LAUNCH.
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            cmd_start = 1'b0; cmd_abort = 1'b0;
            if (p_hs) hs_beats++;
            if (p_start) begin
                act = 1; beat = 0;
            end else if (act && p_hs) begin
                if (p_last) begin
                    taps++; beat = 0;
                    if (p_stop) act = 0;
                end else begin
                    beat++;
                end
            end
            st_q.push_back(gen_start); sp_q.push_back(gen_stop);
            dn_q.push_back(done);      by_q.push_back(busy);
            mon_valid = act;
            mon_last  = act && (beat == beats - 1);
            mon_ready = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            gen_ready = !act;
            if (v.abort_frame > 0 && !aborted && taps >= v.abort_frame) begin
                cmd_abort = 1'b1; aborted = 1;
            end
            if (v.start_drain && !sent2 && gen_stop) begin
                cmd_start = 1'b1; sent2 = 1;
            end
            fd_q.push_back(mon_valid & mon_ready & mon_last);
            rdy_q.push_back(gen_ready);
            ab_q.push_back(cmd_abort);
            p_start = gen_start; p_hs = mon_valid & mon_ready; p_last = mon_last; p_stop = gen_stop;
            if (seen_done) post++;
            if (done) seen_done = 1;
            if (post >= 2) break;
        end
        cmd_start = 1'b0; cmd_abort = 1'b0;
        check({tag, "_done_seen"}, seen_done, 1);

        k = -1; j = -1; sum = 0; reason = 0;
        for (int m = 1; m < fd_q.size(); m++) begin
            idx = m - 1;
            if (k < 0) begin
                if (v.count != 0 && sat(sum) + int'(fd_q[m]) >= v.count - 1) begin
                    k = idx; reason = 1;
                end else if (v.maxc != 0 && sat(idx) + 1 >= v.maxc) begin
                    k = idx; reason = 2;
                end else if (ab_q[m]) begin
                    k = idx; reason = 3;
                end
            end else if (rdy_q[m]) begin
                j = idx;
            end
            sum += int'(fd_q[m]);
            if (j >= 0) break;
        end
        check({tag, "_model_complete"}, (j >= 0), 1);

        e_start = 0; e_stop = 0; e_done = 0; e_busy = 0; first_stop = -1;
        for (int m = 0; m < st_q.size(); m++) begin
            x_stop = (k >= 0) && (j >= 0) && (m >= k + 2) && (m <= j + 1);
            x_done = (j >= 0) && (m == j + 2);
            x_busy = (j < 0) || (m <= j + 2);
            if (st_q[m] != (m == 0)) e_start++;
            if (sp_q[m] != x_stop) e_stop++;
            if (dn_q[m] != x_done) e_done++;
            if (by_q[m] != x_busy) e_busy++;
            if (sp_q[m] && first_stop < 0) first_stop = m;
        end
        check({tag, "_start_window_errs"}, e_start, 0);
        check({tag, "_stop_window_errs"}, e_stop, 0);
        check({tag, "_done_window_errs"}, e_done, 0);
        check({tag, "_busy_window_errs"}, e_busy, 0);
        check({tag, "_frames_model"}, frames_sent, sat(sum));
        check({tag, "_cycles_model"}, cycles_elapsed, sat(j + 1));
        check({tag, "_reason_model"}, stop_reason, reason);
        check({tag, "_port_config"}, gen_port_config, cfg);
        if (v.exp_reason >= 0) check({tag, "_reason"}, stop_reason, v.exp_reason);
        if (v.exp_frames >= 0) check({tag, "_frames"}, frames_sent, v.exp_frames);
        if (v.exp_cycles >= 0) check({tag, "_cycles"}, cycles_elapsed, v.exp_cycles);
        if (v.exp_stop_n >= 0) check({tag, "_stop_rise"}, first_stop, v.exp_stop_n);
        if (v.exp_taps >= 0) begin
            check({tag, "_tap_frames"}, taps, v.exp_taps);
            check({tag, "_tap_beats"}, hs_beats, v.exp_taps * beats);
        end
        if (v.start_drain) begin
            check({tag, "_frames_in_21_22"}, (frames_sent >= 21 && frames_sent <= 22), 1);
            check({tag, "_drain_start_sent"}, sent2, 1);
        end
        last_frames = sat(sum);
    endtask

    vec_t tbl[5];
    vec_t rv;
    int   dn_cnt;

    initial begin
        // count, maxc, fsize, rnd, abort_frame, start_drain, reason, frames, cycles, stop_n, taps
        tbl[0] = '{5,    0,   128, 1'b0, 0,    1'b0, 1, 5,    -1,   -1,  5};
        tbl[1] = '{0,    100, 64,  1'b0, 0,    1'b0, 2, -1,   102,  101, -1};
        tbl[2] = '{1000, 0,   128, 1'b1, 20,   1'b1, 3, -1,   -1,   -1,  -1};
        tbl[3] = '{1,    0,   128, 1'b0, 0,    1'b0, 1, 1,    -1,   2,   1};
        tbl[4] = '{0,    0,   64,  1'b0, 1100, 1'b0, 3, MAXV, MAXV, -1,  -1};

        rst_n = 1'b0; cmd_start = 1'b1; cmd_abort = 1'b1; gen_ready = 1'b1;
        mon_valid = 1'b1; mon_ready = 1'b1; mon_last = 1'b1;
        cfg_port_config = '1; cfg_frame_count = '1; cfg_max_cycles = '1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        cmd_start = 1'b0; cmd_abort = 1'b0; mon_valid = 1'b0; mon_last = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", busy, 0);

        for (int t = 0; t < 5; t++) run_case(tbl[t], $sformatf("vec%0d", t));

        for (int r = 0; r < 6; r++) begin
            rv.count       = int'($urandom_range(0, 8));
            rv.maxc        = ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 60)) : 0;
            rv.fsize       = 64 * int'($urandom_range(1, 4));
            rv.rnd_ready   = 1'($urandom_range(0, 1));
            rv.abort_frame = int'($urandom_range(1, 12));
            rv.start_drain = 1'b0;
            rv.exp_reason = -1; rv.exp_frames = -1; rv.exp_cycles = -1;
            rv.exp_stop_n = -1; rv.exp_taps = -1;
            run_case(rv, $sformatf("rand%0d", r));
        end

        @(negedge clk);
        cfg_frame_count = CW'(7); cmd_start = 1'b1; gen_ready = 1'b0;
        @(negedge clk);
        cmd_start = 1'b0; gen_ready = 1'b1;
        check("start_not_ready_busy", busy, 0);
        check("start_not_ready_hold", frames_sent, last_frames);
        cmd_start = 1'b1; cmd_abort = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0; cmd_abort = 1'b0;
        check("start_with_abort_busy", busy, 0);
        check("start_with_abort_launch", gen_start, 0);

        cfg_port_config = '{dst_addr: 32'h1234_5678, src_addr: 32'h9abc_def0, frame_size: 16'd64};
        cfg_frame_count = '0; cfg_max_cycles = '0; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0; gen_ready = 1'b0;
        mon_valid = 1'b1; mon_ready = 1'b1; mon_last = 1'b1;
        repeat (8) @(negedge clk);
        check("midrun_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("midrun_reset");
        rst_n = 1'b1; gen_ready = 1'b1; mon_valid = 1'b0; mon_last = 1'b0;
        dn_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) dn_cnt++;
        end
        check("midrun_reset_no_done", dn_cnt, 0);
        check("midrun_reset_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
